// File: rtl/counter_reader.sv
// Initiator for the counter-read handshake: sweeps idx 0..NUM_CH-1, captures each
// returned count into a packed snapshot and a running total, and reports done/error.
module counter_reader #(
    parameter int NUM_CH  = 5,
    parameter int DW      = 5,
    parameter int IW      = 3,
    parameter int TW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 idle,
    input  logic                 valid,
    input  logic [DW-1:0]        data_in,
    output logic                 req,
    output logic [IW-1:0]        idx,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [NUM_CH*DW-1:0] snapshot,
    output logic [TW-1:0]        total
);

    localparam int TMW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [TMW-1:0]      timer_q, timer_d;
    logic [TW-1:0]       total_q, total_d;
    logic                error_q, error_d;
    logic [NUM_CH*DW-1:0] snap_q, snap_d;

    logic accept;
    logic last_ch;
    logic timed_out;
    logic clear;

    // valid already implies idle on the counter side; qualifying again keeps a
    // stray valid outside an idle window from being captured.
    assign accept    = (state_q == ST_REQ) && valid && idle;
    assign last_ch   = (idx_q == IW'(NUM_CH - 1));
    assign timed_out = (timer_q == TMW'(TIMEOUT - 1));
    assign clear     = (state_q == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            total_q <= '0;
            error_q <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            total_q <= total_d;
            error_q <= error_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ: begin
                if (accept) begin
                    if (last_ch) state_d = ST_DONE;
                end else if (timed_out) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        timer_d = timer_q;
        total_d = total_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    timer_d = '0;
                    total_d = '0;
                    error_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (accept) begin
                    timer_d = '0;
                    total_d = total_q + TW'(data_in);
                    if (!last_ch) idx_d = idx_q + IW'(1);
                end else if (timed_out) begin
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMW'(1);
                end
            end
            ST_DONE: idx_d = '0;
            ST_ERR:  idx_d = '0;
            default: idx_d = '0;
        endcase
    end

    // Each channel slot is cleared on an accepted start and loaded when its idx is captured.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign snap_d[gi*DW +: DW] = clear ? '0 :
                                         (accept && idx_q == IW'(gi)) ? data_in :
                                         snap_q[gi*DW +: DW];
        end
    endgenerate

    always_comb begin
        req      = (state_q == ST_REQ);
        busy     = (state_q == ST_REQ);
        done     = (state_q == ST_DONE);
        idx      = idx_q;
        error    = error_q;
        snapshot = snap_q;
        total    = total_q;
    end

endmodule

// File: tb/tb_counter_reader.sv
// Bench for counter_reader: a counter-side model answers req, a scoreboard holds
// the expected outcome of each sweep and is checked when done/error appears.
module tb_counter_reader;

    localparam int NUM_CH  = 5;
    localparam int DW      = 5;
    localparam int IW      = 3;
    localparam int TW      = 8;
    localparam int TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 idle;
    logic                 valid;
    logic [DW-1:0]        data_in;
    logic                 req;
    logic [IW-1:0]        idx;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [NUM_CH*DW-1:0] snapshot;
    logic [TW-1:0]        total;

    logic [DW-1:0] cnt [NUM_CH];

    typedef struct {
        logic                 is_err;
        logic [NUM_CH*DW-1:0] snap;
        logic [TW-1:0]        tot;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic err_prev;

    int checks = 0;
    int errors = 0;

    counter_reader #(
        .NUM_CH(NUM_CH), .DW(DW), .IW(IW), .TW(TW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .idle(idle), .valid(valid),
        .data_in(data_in), .req(req), .idx(idx), .busy(busy), .done(done),
        .error(error), .snapshot(snapshot), .total(total)
    );

    always #5 clk = ~clk;

    // Counter side: combinational valid, count selected by idx.
    assign valid   = idle && req;
    assign data_in = (int'(idx) < NUM_CH) ? cnt[idx] : '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            err_prev <= 1'b0;
        end else begin
            if (done || (error && !err_prev)) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_outcome", 64'(sb_q.size()), 64'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_kind_done", 64'(done), 64'(!mon_e.is_err));
                    check("sb_snapshot", 64'(snapshot), 64'(mon_e.snap));
                    check("sb_total", 64'(total), 64'(mon_e.tot));
                    $display("outcome %s snapshot=%h total=%0d", done ? "done" : "error", snapshot, total);
                end
            end
            err_prev <= error;
        end
    end

    // low_mask bit c: idle is low during sweep cycle c; start_mask bit c: start pulsed in cycle c.
    task automatic run_sweep(input string tag, input logic [63:0] low_mask, input logic [63:0] start_mask);
        exp_t e;
        int   idx_m;
        int   tmr_m;
        int   outcome_c;
        e.snap = '0;
        e.tot = '0;
        e.is_err = 1'b0;
        idx_m = 0;
        tmr_m = 0;
        outcome_c = 0;
        for (int c = 1; c < 64 && outcome_c == 0; c++) begin
            if (!low_mask[c]) begin
                e.snap[idx_m*DW +: DW] = cnt[idx_m];
                e.tot = e.tot + TW'(cnt[idx_m]);
                tmr_m = 0;
                if (idx_m == NUM_CH - 1) outcome_c = c + 1;
                else idx_m++;
            end else if (tmr_m == TIMEOUT - 1) begin
                e.is_err = 1'b1;
                outcome_c = c + 1;
            end else begin
                tmr_m++;
            end
        end
        if (outcome_c == 0) begin
            check({tag, "_model_bound"}, 64'(outcome_c), 64'd1);
            return;
        end
        sb_q.push_back(e);

        start = 1'b1;
        tick();
        start = 1'b0;
        idx_m = 0;
        check({tag, "_err_cleared"}, 64'(error), 64'd0);
        for (int c = 1; c < outcome_c; c++) begin
            idle  = !low_mask[c];
            start = start_mask[c];
            check({tag, "_req"}, 64'(req), 64'd1);
            check({tag, "_idx"}, 64'(idx), 64'(idx_m));
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_done_early"}, 64'(done), 64'd0);
            if (!low_mask[c] && idx_m < NUM_CH - 1) idx_m++;
            tick();
        end
        idle  = 1'b1;
        start = 1'b0;
        check({tag, "_end_req"}, 64'(req), 64'd0);
        check({tag, "_end_busy"}, 64'(busy), 64'd0);
        check({tag, "_end_done"}, 64'(done), 64'(!e.is_err));
        tick();
        check({tag, "_done_pulse_len"}, 64'(done), 64'd0);
        check({tag, "_idx_back"}, 64'(idx), 64'd0);
        check({tag, "_error_flag"}, 64'(error), 64'(e.is_err));
        check({tag, "_snap_hold"}, 64'(snapshot), 64'(e.snap));
        check({tag, "_total_hold"}, 64'(total), 64'(e.tot));
        $display("sweep %s finished at cycle %0d error=%0d", tag, outcome_c, e.is_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH*DW-1:0] snap_ref;
        reset = 1'b1;
        start = 1'b0;
        idle  = 1'b1;
        cnt[0] = 5'd3; cnt[1] = 5'd0; cnt[2] = 5'd7; cnt[3] = 5'd31; cnt[4] = 5'd1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_req", 64'(req), 64'd0);
        check("rst_idx", 64'(idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_snapshot", 64'(snapshot), 64'd0);
        check("rst_total", 64'(total), 64'd0);
        tick();

        // 1: plain sweep
        run_sweep("t1", 64'h0, 64'h0);
        snap_ref = {5'd1, 5'd31, 5'd7, 5'd0, 5'd3};
        check("t1_snapshot_literal", 64'(snapshot), 64'(snap_ref));
        check("t1_total_literal", 64'(total), 64'd42);
        tick();
        tick();
        check("t1_snapshot_stable", 64'(snapshot), 64'(snap_ref));

        // 2: idle low for three cycles while idx=2
        run_sweep("t2", 64'h38, 64'h0);
        check("t2_total_literal", 64'(total), 64'd42);

        // 3: idle never high -> timeout, error sticky, next start clears it
        run_sweep("t3", 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
        tick();
        tick();
        tick();
        check("t3_error_sticky", 64'(error), 64'd1);
        check("t3_busy_idle", 64'(busy), 64'd0);
        run_sweep("t3b", 64'h0, 64'h0);

        // 4: reset mid-sweep while idx=3
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("t4_idx3", 64'(idx), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_req", 64'(req), 64'd0);
        check("t4_idx", 64'(idx), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_snapshot", 64'(snapshot), 64'd0);
        check("t4_total", 64'(total), 64'd0);
        tick();

        // 5: start pulses mid-sweep ignored; then a fresh sweep sees new counts
        run_sweep("t5", 64'h0, 64'h14);
        cnt[1] = cnt[1] + 5'd4;
        cnt[3] = cnt[3] - 5'd10;
        tick();
        run_sweep("t5b", 64'h0, 64'h0);
        check("t5b_total_literal", 64'(total), 64'd36);

        // 6: counter 0 popped 33 times wraps to 1
        cnt[0] = '0;
        for (int p = 0; p < 33; p++) cnt[0] = cnt[0] + 5'd1;
        run_sweep("t6", 64'h0, 64'h0);
        check("t6_slot0", 64'(snapshot[DW-1:0]), 64'd1);
        check("t6_total_literal", 64'(total), 64'd34);

        tick();
        tick();
        check("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
